uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
// PURPOSE
//  Receive path of the APB UART: oversamples serial rx_i, detects start bit, samples
//  data/parity/stop at bit centre, and presents each byte with a one-cycle valid
//  pulse to the RX FIFO write port. Mirrors the TX holding-register/shifter path;
//  the byte register is only written on a completed frame.
// PARAMETERS
//  DATA_W       8   data bits per frame, LSB first
//  OVERSAMPLE   16  baud_tick_i pulses per bit period (even, >=8)
//  SYNC_STAGES  2   flops in rx_i synchronizer (>=2)
// PORTS
//  clk_i          in   1       system clock
//  rst_ni         in   1       asynchronous, active-low reset
//  baud_tick_i    in   1       1-cycle enable at OVERSAMPLE x baud (from baud gen)
//  rx_i           in   1       async serial line, idle high
//  parity_en_i    in   1       1: parity bit follows data
//  parity_odd_i   in   1       1: odd parity, 0: even
//  fifo_full_i    in   1       RX FIFO full
//  rx_data_o      out  DATA_W  last received byte, held until next valid frame
//  rx_valid_o     out  1       1-cycle write strobe to RX FIFO
//  parity_err_o   out  1       1-cycle pulse, coincident with frame end
//  frame_err_o    out  1       1-cycle pulse, stop bit sampled 0
//  overrun_err_o  out  1       1-cycle pulse, byte dropped because fifo_full_i
//  busy_o         out  1       high whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, rx_data_o=0, state IDLE, counters 0, sync flops = 1.
//  FSM advances only on cycles with baud_tick_i=1; tick_cnt counts 0..OVERSAMPLE-1.
//  IDLE : on tick with synced rx=0 -> START, tick_cnt=0; latch parity_en/odd cfg.
//  START: at tick_cnt==OVERSAMPLE/2-1 sample: rx=1 -> IDLE (glitch, no outputs);
//         rx=0 -> DATA, tick_cnt=0, bit_cnt=0.
//  DATA : at tick_cnt==OVERSAMPLE-1 shift sample into MSB (LSB-first), bit_cnt++;
//         after bit DATA_W-1 -> PARITY if latched parity_en else STOP.
//  PARITY: sample at OVERSAMPLE-1; err = (^data ^ bit) != latched parity_odd.
//  STOP : sample at OVERSAMPLE-1 (stop-bit centre), then -> IDLE same tick so a
//         back-to-back start bit is detected within half a bit.
//  Frame end (STOP sample cycle, registered, visible next clk):
//   - stop=1, !fifo_full_i: rx_data_o<=byte, rx_valid_o=1, parity_err_o=perr.
//   - stop=0: frame_err_o=1, rx_valid_o=0, rx_data_o unchanged; parity_err_o=0.
//   - stop=1, fifo_full_i: overrun_err_o=1, rx_valid_o=0, rx_data_o unchanged.
//  Pulses never repeat: each frame yields exactly one cycle of outputs.
//  Latency: rx_valid_o rises 1 clk after the baud tick at stop-bit centre.
//  Config inputs changing mid-frame take effect from next start bit only.
//  rx held low (break): frame_err_o once, then wait in IDLE for rx=1 before a new
//  start is accepted (idle_seen flag set on any high sample in IDLE).
//  Async reset mid-frame: immediate return to IDLE, partial byte discarded.
//  Counter widths: $clog2(OVERSAMPLE) and $clog2(DATA_W+1); no wrap past limits.
// STRUCTURE
//  uart_pkg: rx_state_e {RX_IDLE,RX_START,RX_DATA,RX_PARITY,RX_STOP}, default
//  UART_DATA_W/UART_OVERSAMPLE constants shared with TX side.
//  Sub-module: uart_sync (SYNC_STAGES flop synchronizer, reset value 1) on rx_i.
//  Remaining: FSM, tick/bit counters, shift register, output register in this file.
// TESTING (OVERSAMPLE=16, baud_tick_i every 4 clk)
//  1. 0xA5, no parity, stop=1 -> single rx_valid_o, rx_data_o=0xA5, no errors.
//  2. 0x3C, odd parity bit=1 -> valid, parity_err_o=0; same with bit=0 -> valid
//     plus parity_err_o=1 same cycle, rx_data_o=0x3C.
//  3. rx low for 5 ticks then high -> no outputs, busy_o returns 0, next 0x55 ok.
//  4. 0x81 with stop=0 -> frame_err_o=1, rx_valid_o=0, rx_data_o keeps prior 0x55.
//  5. fifo_full_i=1 across frame 0xFF -> overrun_err_o=1, no valid; then full=0,
//     back-to-back 0x01,0x02 with no idle gap -> two valids, data 0x01 then 0x02.
//  6. rst_ni low during bit 4 of 0xF0 -> outputs 0 at once; after release, 0x0F ok.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and RX FSM state encodings.
// The TX side imports the same constants, so both paths agree on frame shape.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef logic [2:0] rx_state_e;

  localparam rx_state_e RX_IDLE   = 3'd0;
  localparam rx_state_e RX_START  = 3'd1;
  localparam rx_state_e RX_DATA   = 3'd2;
  localparam rx_state_e RX_PARITY = 3'd3;
  localparam rx_state_e RX_STOP   = 3'd4;

  // Parity check: the XOR of the data bits and the parity bit must equal
  // the odd-parity flag.
  function automatic logic parity_bad(input logic data_xor, input logic bit_val,
                                      input logic odd);
    return (data_xor ^ bit_val) != odd;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous level input.
// The flops reset to 1 so that an idle-high line does not look like a start bit.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff <= '1;
    else         ff <= {ff[STAGES-2:0], din};
  end

  assign dout = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive path: oversampled start detection, mid-bit sampling of data,
// parity and stop bits, and one-cycle result strobes toward the RX FIFO.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_W      = UART_DATA_W,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              baud_tick_i,
  input  logic              rx_i,
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  input  logic              fifo_full_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_err_o,
  output logic              busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic              rx_s;
  rx_state_e         state;
  logic [TW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              par_en_q;
  logic              par_odd_q;
  logic              idle_seen;
  logic              at_mid;
  logic              at_end;
  logic              frame_end;
  logic              perr;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .din   (rx_i),
    .dout  (rx_s)
  );

  assign at_mid    = (tick_cnt == TICK_MID);
  assign at_end    = (tick_cnt == TICK_END);
  assign frame_end = baud_tick_i && (state == RX_STOP) && at_end;
  assign perr      = par_en_q && parity_bad(^shreg, par_bit, par_odd_q);
  assign busy_o    = (state != RX_IDLE);

  // A start is only accepted after the line has been seen high in IDLE,
  // so a held-low break produces one frame error and no phantom frames.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= RX_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      idle_seen <= 1'b0;
    end else if (baud_tick_i) begin
      case (state)
        RX_IDLE: begin
          tick_cnt <= '0;
          if (rx_s) begin
            idle_seen <= 1'b1;
          end else if (idle_seen) begin
            state     <= RX_START;
            par_en_q  <= parity_en_i;
            par_odd_q <= parity_odd_i;
          end
        end
        RX_START: begin
          if (at_mid) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (at_end) begin
            tick_cnt <= '0;
            shreg    <= {rx_s, shreg[DATA_W-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= par_en_q ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (at_end) begin
            tick_cnt <= '0;
            par_bit  <= rx_s;
            state    <= RX_STOP;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (at_end) begin
            tick_cnt  <= '0;
            idle_seen <= rx_s;
            state     <= RX_IDLE;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state    <= RX_IDLE;
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // Result strobes default low every cycle, so each frame yields one pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
      if (frame_end) begin
        if (!rx_s) begin
          frame_err_o <= 1'b1;
        end else if (fifo_full_i) begin
          overrun_err_o <= 1'b1;
        end else begin
          rx_data_o    <= shreg;
          rx_valid_o   <= 1'b1;
          parity_err_o <= perr;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for the UART receiver: frames are driven bit by bit and the
// expected strobe set for each frame is queued, then matched at the outputs.
module tb_uart_rx_deserializer;

  localparam int BIT_CLKS = 64;  // 16 ticks x 4 clk per tick

  typedef struct {
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       ovr;
    logic [7:0] data;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       baud_tick_i;
  logic       rx_i = 1'b1;
  logic       parity_en_i = 1'b0;
  logic       parity_odd_i = 1'b0;
  logic       fifo_full_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o;

  logic [1:0] tick_div = '0;
  exp_t       sb[$];
  logic [7:0] model_data = 8'h00;
  int         total = 0;
  int         bad = 0;

  uart_rx_deserializer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .baud_tick_i  (baud_tick_i),
    .rx_i         (rx_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .fifo_full_i  (fifo_full_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overrun_err_o(overrun_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) tick_div <= tick_div + 2'd1;
  assign baud_tick_i = (tick_div == 2'd3);

  // Output monitor: every strobe cycle must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni && (rx_valid_o || parity_err_o || frame_err_o || overrun_err_o)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: got v=%0b p=%0b f=%0b o=%0b, required none",
                 rx_valid_o, parity_err_o, frame_err_o, overrun_err_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({rx_valid_o, parity_err_o, frame_err_o, overrun_err_o} !==
            {e.valid, e.perr, e.ferr, e.ovr}) begin
          bad++;
          $display("FAIL strobes: got v=%0b p=%0b f=%0b o=%0b, required v=%0b p=%0b f=%0b o=%0b",
                   rx_valid_o, parity_err_o, frame_err_o, overrun_err_o,
                   e.valid, e.perr, e.ferr, e.ovr);
        end
        total++;
        if (rx_data_o !== e.data) begin
          bad++;
          $display("FAIL rx_data: got %02h, required %02h", rx_data_o, e.data);
        end
      end
    end
  end

  task automatic push_valid(input logic [7:0] d, input logic perr);
    exp_t e;
    e = '{valid: 1'b1, perr: perr, ferr: 1'b0, ovr: 1'b0, data: d};
    model_data = d;
    sb.push_back(e);
  endtask

  task automatic push_err(input logic ferr, input logic ovr);
    exp_t e;
    e = '{valid: 1'b0, perr: 1'b0, ferr: ferr, ovr: ovr, data: model_data};
    sb.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(posedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                            input logic stop, input int gap_bits);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    drive_bit(stop);
    rx_i = 1'b1;
    repeat (gap_bits * BIT_CLKS) @(posedge clk_i);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk_i);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d expected strobes still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    rx_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if ({rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %05b, required 00000",
               {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o});
    end
    total++;
    if (rx_data_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got %02h, required 00", rx_data_o);
    end
    rst_ni = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk_i);
  endtask

  task automatic test_basic;
    push_valid(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 2);
    wait_drain("basic");
  endtask

  task automatic test_parity;
    parity_en_i = 1'b1;
    parity_odd_i = 1'b1;
    push_valid(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1);
    push_valid(8'h3C, 1'b1);
    // Config changes mid-frame must not affect the frame in flight.
    fork
      begin
        repeat (3 * BIT_CLKS) @(posedge clk_i);
        parity_en_i = 1'b0;
      end
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 2);
    join
    wait_drain("parity");
    parity_odd_i = 1'b0;
  endtask

  task automatic test_glitch;
    rx_i = 1'b0;
    repeat (20) @(posedge clk_i);
    rx_i = 1'b1;
    repeat (BIT_CLKS) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL glitch_busy: got %0b, required 0", busy_o);
    end
    push_valid(8'h55, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 2);
    wait_drain("glitch");
  endtask

  task automatic test_frame_err;
    push_err(1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 2);
    wait_drain("frame_err");
  endtask

  task automatic test_overrun;
    fifo_full_i = 1'b1;
    push_err(1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1);
    wait_drain("overrun");
    fifo_full_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    push_valid(8'h01, 1'b0);
    push_valid(8'h02, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8'h02, 1'b0, 1'b0, 1'b1, 2);
    wait_drain("back_to_back");
  endtask

  task automatic test_reset_mid;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx_i = 1'b1;
    repeat (BIT_CLKS / 2) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL midframe_busy: got %0b, required 1", busy_o);
    end
    rst_ni = 1'b0;
    model_data = 8'h00;
    #1;
    total++;
    if ({rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o} !== 5'b0) begin
      bad++;
      $display("FAIL async_reset_flags: got %05b, required 00000",
               {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o});
    end
    total++;
    if (rx_data_o !== 8'h00) begin
      bad++;
      $display("FAIL async_reset_data: got %02h, required 00", rx_data_o);
    end
    repeat (4) @(posedge clk_i);
    rst_ni = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk_i);
    push_valid(8'h0F, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 2);
    wait_drain("after_reset");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
    repeat (20) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
